// File: rtl/sym_stream_arbiter.sv
// Round-robin arbiter that lends one 2-bit symbol datapath to NREQ requesters, one packet at a time.
// A packet ends on terminator 3 or an idle timeout, followed by a one-cycle datapath clear.
module sym_stream_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 15,
    parameter int TW      = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [2*NREQ-1:0] req_sym,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   grant,
    output logic [1:0]        dp_in,
    output logic              dp_valid,
    output logic              dp_clr,
    output logic              busy,
    output logic              timeout_evt
);

    localparam int            PW       = $clog2(NREQ);
    localparam logic [1:0]    TERM     = 2'd3;
    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LOCK, ST_FLUSH} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [NREQ-1:0] r_grant;
    logic [PW-1:0]   r_gidx;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   w_pick;
    logic [PW-1:0]   w_ptr_next;
    logic [TW-1:0]   r_idle_cnt;
    logic [1:0]      r_dp_in;
    logic [1:0]      w_sym;
    logic            r_dp_valid;
    logic            r_dp_clr;
    logic            r_timeout;
    logic            w_hs;
    logic            w_stall_last;

    // Nearest valid requester at or after the round-robin pointer; smallest offset is written last.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_pick = r_ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && (PW'((int'(r_ptr) + k) % NREQ) == PW'(i)))
                    w_pick = PW'(i);
            end
        end
    end

    always_comb begin
        w_sym = 2'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gidx == PW'(i))
                w_sym = req_sym[2*i +: 2];
        end
    end

    assign w_ptr_next = (r_gidx == PW'(NREQ - 1)) ? '0 : r_gidx + PW'(1);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (|req_valid) w_next = ST_LOCK;
            ST_LOCK: begin
                if (w_hs && (w_sym == TERM)) w_next = ST_FLUSH;
                else if (w_stall_last)       w_next = ST_FLUSH;
            end
            ST_FLUSH: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Output logic, driven from registers only.
    always_comb begin
        req_ready = r_grant & {NREQ{r_state == ST_LOCK}};
        busy      = (r_state != ST_IDLE);
    end

    assign w_hs         = |(req_valid & req_ready);
    assign w_stall_last = (r_state == ST_LOCK) && !w_hs && (r_idle_cnt == CNT_LAST);

    // Grant, pointer, idle counter and registered datapath outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_grant    <= '0;
            r_gidx     <= '0;
            r_ptr      <= '0;
            r_idle_cnt <= '0;
            r_dp_in    <= 2'd0;
            r_dp_valid <= 1'b0;
            r_dp_clr   <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_dp_valid <= 1'b0;
            r_dp_clr   <= 1'b0;
            r_timeout  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        r_grant    <= NREQ'(1) << w_pick;
                        r_gidx     <= w_pick;
                        r_idle_cnt <= '0;
                    end
                end
                ST_LOCK: begin
                    if (w_hs) begin
                        r_dp_in    <= w_sym;
                        r_dp_valid <= 1'b1;
                        r_idle_cnt <= '0;
                    end else begin
                        if (r_idle_cnt != CNT_LAST) r_idle_cnt <= r_idle_cnt + TW'(1);
                        if (w_stall_last)           r_timeout  <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    r_dp_clr <= 1'b1;
                    r_grant  <= '0;
                    r_ptr    <= w_ptr_next;
                end
                default: ;
            endcase
        end
    end

    assign grant       = r_grant;
    assign dp_in       = r_dp_in;
    assign dp_valid    = r_dp_valid;
    assign dp_clr      = r_dp_clr;
    assign timeout_evt = r_timeout;

endmodule

// File: tb/tb_sym_stream_arbiter.sv
// Randomized bench for sym_stream_arbiter: a packet-level reference model feeds a scoreboard
// that a separate monitor drains one cycle at a time and on every forwarded symbol.
module tb_sym_stream_arbiter;

    localparam int NREQ    = 3;
    localparam int TIMEOUT = 15;
    localparam int TW      = 4;
    localparam int NCYC    = 5000;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NREQ-1:0]   req_valid;
    logic [2*NREQ-1:0] req_sym;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   grant;
    logic [1:0]        dp_in;
    logic              dp_valid;
    logic              dp_clr;
    logic              busy;
    logic              timeout_evt;

    sym_stream_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_sym     (req_sym),
        .req_ready   (req_ready),
        .grant       (grant),
        .dp_in       (dp_in),
        .dp_valid    (dp_valid),
        .dp_clr      (dp_clr),
        .busy        (busy),
        .timeout_evt (timeout_evt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              tag;
        logic [NREQ-1:0] grant;
        logic [NREQ-1:0] ready;
        logic            busy;
        logic            dv;
        logic [1:0]      din;
        logic            clr;
        logic            tevt;
    } snap_t;

    typedef struct {
        int              tag;
        logic [1:0]      sym;
        logic [NREQ-1:0] grant;
    } fwd_t;

    snap_t snap_q[$];
    fwd_t  fwd_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    bit    done     = 1'b0;

    // Packet-level view of the arbiter: who owns the datapath, whether the packet is over,
    // how many cycles the owner has been silent, and where the round-robin search starts.
    int         m_owner   = -1;
    bit         m_closing = 1'b0;
    int         m_ptr     = 0;
    int         m_stall   = 0;
    logic [1:0] m_din     = 2'd0;

    task automatic check(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, tag, act, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Advance the model across the coming rising edge and queue what the DUT must show after it.
    task automatic model_step(input int tag);
        int    sym;
        bit    ndv;
        bit    nclr;
        bit    ntevt;
        fwd_t  f;
        snap_t s;
        ndv   = 1'b0;
        nclr  = 1'b0;
        ntevt = 1'b0;
        if (!reset_n) begin
            m_owner   = -1;
            m_closing = 1'b0;
            m_ptr     = 0;
            m_stall   = 0;
            m_din     = 2'd0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (m_ptr + k) % NREQ;
                if (m_owner < 0 && req_valid[c]) begin
                    m_owner = c;
                    m_stall = 0;
                end
            end
        end else if (m_closing) begin
            nclr      = 1'b1;
            m_ptr     = (m_owner + 1) % NREQ;
            m_owner   = -1;
            m_closing = 1'b0;
        end else if (req_valid[m_owner]) begin
            sym     = int'((req_sym >> (2 * m_owner)) & 3);
            m_din   = 2'(sym);
            ndv     = 1'b1;
            m_stall = 0;
            f.tag   = tag;
            f.sym   = 2'(sym);
            f.grant = onehot(m_owner);
            fwd_q.push_back(f);
            if (sym == 3) m_closing = 1'b1;
        end else begin
            m_stall++;
            if (m_stall == TIMEOUT) begin
                m_closing = 1'b1;
                ntevt     = 1'b1;
            end
        end
        s.tag   = tag;
        s.grant = (m_owner >= 0) ? onehot(m_owner) : '0;
        s.ready = (m_owner >= 0 && !m_closing) ? onehot(m_owner) : '0;
        s.busy  = (m_owner >= 0);
        s.dv    = ndv;
        s.din   = m_din;
        s.clr   = nclr;
        s.tevt  = ntevt;
        snap_q.push_back(s);
    endtask

    // Stimulus: reset with everyone requesting, then random traffic with silent spells
    // long enough to force timeouts and occasional mid-packet resets.
    initial begin
        int silent[NREQ];
        int rst_hold;
        int r;
        rst_hold  = 0;
        for (int i = 0; i < NREQ; i++) silent[i] = 0;
        reset_n   = 1'b0;
        req_valid = '0;
        req_sym   = '0;
        for (int n = 0; n < NCYC; n++) begin
            if (n < 2) begin
                reset_n   = 1'b0;
                req_valid = '1;
                req_sym   = '1;
            end else begin
                if (rst_hold > 0) begin
                    reset_n = 1'b0;
                    rst_hold--;
                end else if ($urandom_range(0, 399) == 0) begin
                    reset_n  = 1'b0;
                    rst_hold = $urandom_range(0, 1);
                end else begin
                    reset_n = 1'b1;
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (silent[i] > 0) begin
                        silent[i]--;
                        req_valid[i] = 1'b0;
                    end else if ($urandom_range(0, 29) == 0) begin
                        silent[i]    = $urandom_range(8, 24);
                        req_valid[i] = 1'b0;
                    end else begin
                        req_valid[i] = ($urandom_range(0, 99) < 70);
                    end
                    r = $urandom_range(0, 29);
                    req_sym[2*i +: 2] = (r < 5) ? 2'd3 : 2'($urandom_range(0, 2));
                end
            end
            model_step(n);
            @(negedge clk);
        end
        done = 1'b1;
        repeat (2) @(negedge clk);
        check("fwd_leftover", NCYC, fwd_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Monitor: one snapshot per cycle, plus one forwarded-symbol item per dp_valid.
    initial begin
        int    m;
        snap_t s;
        fwd_t  f;
        m = 0;
        forever begin
            @(posedge clk);
            #1;
            if (snap_q.size() > 0) begin
                s = snap_q.pop_front();
                check("grant",       m, grant,       s.grant);
                check("req_ready",   m, req_ready,   s.ready);
                check("busy",        m, busy,        s.busy);
                check("dp_valid",    m, dp_valid,    s.dv);
                check("dp_in",       m, dp_in,       s.din);
                check("dp_clr",      m, dp_clr,      s.clr);
                check("timeout_evt", m, timeout_evt, s.tevt);
            end
            if (dp_valid === 1'b1) begin
                if (fwd_q.size() == 0) begin
                    check("fwd_spurious", m, dp_valid, 1'b0);
                end else begin
                    f = fwd_q.pop_front();
                    check("fwd_cycle", m, m,     f.tag);
                    check("fwd_sym",   m, dp_in, f.sym);
                    check("fwd_grant", m, grant, f.grant);
                end
            end
            m++;
        end
    end

endmodule
